// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock with a registered carry,
// valid/ready handshakes on the operand and result sides.
module addsub_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N       = WIDTH / CHUNK;
    localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              c_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              ovf_q;
    logic              zero_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [CHUNK:0]    chunk_sum;
    logic              msb_cin;
    logic [WIDTH-1:0]  res_d;

    // Operands shift right one chunk per cycle; result chunks enter from the top, so after
    // N cycles res_d holds the full-width sum in place.
    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
        msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
        res_d     = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        c_q        <= sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    c_q   <= chunk_sum[CHUNK];
                    res_q <= res_d;
                    if (cnt_q == LastCnt) begin
                        sum_q       <= res_d;
                        carry_q     <= chunk_sum[CHUNK];
                        ovf_q       <= msb_cin ^ chunk_sum[CHUNK];
                        zero_q      <= (res_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: three instances (CHUNK = 4, 16, 1) at WIDTH = 16, table vectors,
// back-pressure and reset-abort sequences, and random operations against a reference model.
module tb_addsub_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]       iv;
    logic [2:0]       ir;
    logic [2:0][15:0] av;
    logic [2:0][15:0] bv;
    logic [2:0]       sb;
    logic [2:0]       ov;
    logic [2:0]       ordy;
    logic [2:0][15:0] sm;
    logic [2:0]       cy;
    logic [2:0]       vf;
    logic [2:0]       zr;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        addsub_seq #(
            .WIDTH(16),
            .CHUNK((g == 0) ? 4 : ((g == 1) ? 16 : 1))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .a         (av[g]),
            .b         (bv[g]),
            .sub       (sb[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .sum       (sm[g]),
            .carry     (cy[g]),
            .overflow  (vf[g]),
            .zero      (zr[g])
        );
    end

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        ev;
        logic        ez;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t        r;
        logic [15:0] yx;
        logic [16:0] full;
        yx   = y ^ {16{s}};
        full = {1'b0, x} + {1'b0, yx} + {16'h0, s};
        r.s  = full[15:0];
        r.c  = full[16];
        r.v  = (x[15] == yx[15]) && (full[15] != x[15]);
        r.z  = (full[15:0] == 16'h0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accepting edge.
    task automatic start_op(input int d, input logic [15:0] x, input logic [15:0] y,
                            input logic s);
        iv[d] = 1'b1;
        av[d] = x;
        bv[d] = y;
        sb[d] = s;
        tick();
        iv[d] = 1'b0;
        av[d] = 16'($urandom);
        bv[d] = 16'($urandom);
        sb[d] = 1'($urandom);
    endtask

    // Waits for out_valid (bounded), checks latency and pops/compares the scoreboard.
    task automatic finish_op(input int d, input string nm);
        int   cyc;
        exp_t e;
        for (cyc = 1; cyc <= 40; cyc++) begin
            iv[d] = 1'($urandom);
            av[d] = 16'($urandom);
            bv[d] = 16'($urandom);
            tick();
            if (ov[d]) break;
        end
        iv[d] = 1'b0;
        chk($sformatf("%s latency", nm), 32'(cyc), 32'(lat_of(d)));
        e = sbq.pop_front();
        chk($sformatf("%s result", nm), {13'h0, cy[d], vf[d], zr[d], sm[d]},
            {13'h0, e.c, e.v, e.z, e.s});
    endtask

    task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input exp_t e, input string nm);
        sbq.push_back(e);
        start_op(d, x, y, s);
        finish_op(d, nm);
        tick();
    endtask

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        iv   = '0;
        av   = '0;
        bv   = '0;
        sb   = '0;
        ordy = '1;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset state d%0d", d), {26'h0, ir[d], ov[d], cy[d], vf[d], zr[d], 1'b0}
                | {16'h0, sm[d]}, {26'h0, 1'b1, 5'b0} | 32'h0);
        end

        for (int i = 0; i < 7; i++) begin
            e = '{vecs[i].es, vecs[i].ec, vecs[i].ev, vecs[i].ez};
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, e, $sformatf("vec%0d", i));
        end

        // Back-pressure: result held while out_ready is low and inputs churn.
        ordy[0] = 1'b0;
        sbq.push_back('{16'h3333, 1'b0, 1'b0, 1'b0});
        start_op(0, 16'h1111, 16'h2222, 1'b0);
        finish_op(0, "bp");
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'($urandom);
            av[0] = 16'($urandom);
            bv[0] = 16'($urandom);
            tick();
            chk($sformatf("bp hold %0d", i), {14'h0, ov[0], ir[0], sm[0]},
                {14'h0, 1'b1, 1'b0, 16'h3333});
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp release handshake", {30'h0, ov[0], ir[0]}, {30'h0, 1'b0, 1'b1});
        chk("bp release retain", {16'h0, sm[0]}, {16'h0, 16'h3333});
        tick();

        // Reset two cycles into RUN aborts the operation.
        start_op(0, 16'h1234, 16'h0FFF, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort outputs", {12'h0, ov[0], cy[0], vf[0], zr[0], sm[0]}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort in_ready", {31'h0, ir[0]}, 32'h1);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                seen = seen | ov[0];
            end
            chk("abort no out_valid", {31'h0, seen}, 32'h0);
        end
        run_op(0, 16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0}, "after abort");

        for (int d = 0; d < 3; d++) begin
            int n;
            n = (d == 0) ? 50 : 1000;
            for (int i = 0; i < n; i++) begin
                logic [15:0] x;
                logic [15:0] y;
                logic        s;
                x = 16'($urandom);
                y = 16'($urandom);
                s = 1'($urandom);
                if (i % 7 == 0) y = x;
                if (i % 11 == 0) x = 16'h8000;
                run_op(d, x, y, s, model(x, y, s), $sformatf("rnd d%0d #%0d", d, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor.
- Processes CHUNK bits per clock with a registered carry chain, so wide operands do not need a full-width combinational ripple.
- Operands and mode enter through a valid/ready handshake; the result and flags leave through a second valid/ready handshake.
- Datapath building block for the arithmetic units.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock; N = WIDTH/CHUNK is the cycle count per operation (CHUNK = WIDTH gives single-cycle compute).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on a, b, sub are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry out of the MSB of A + (B xor sub) + sub; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB xor carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, chunk counter = 0, internal carry = 0.
  - sum = 0, carry = 0, overflow = 0, zero = 0.
  - out_valid = 0, in_ready = 1 once rst deasserts.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1, capture a, b xor {WIDTH{sub}}, and carry-in = sub.
  - Clear the counter and go to RUN.
  - The operand buses are not sampled again for this operation.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge adds chunk k (bits k*CHUNK +: CHUNK, LSB chunk first) with the registered carry.
  - The chunk sum is written into the result register; the chunk carry-out goes into the carry register; k increments.
  - On the edge that processes chunk N-1:
    - latch carry = carry out of bit WIDTH-1;
    - latch overflow = carry into bit WIDTH-1 xor carry out of bit WIDTH-1;
    - latch zero = full-width result == 0;
    - go to DONE.
- DONE:
  - out_valid = 1; sum and flags are held stable.
  - On an edge with out_ready = 1, go to IDLE and drop out_valid.
  - While out_ready = 0, hold indefinitely.
  - in_ready = 0, so no new operation is accepted.
- Latency:
  - out_valid rises exactly N cycles after the accepting edge.
  - Minimum spacing between accepts is N+2 cycles, with out_ready held high.
- Output retention: sum and flags keep their last values after leaving DONE until the next completion overwrites them; they are valid only while out_valid = 1.
- Mid-operation input changes: changes on a, b, sub or in_valid during RUN or DONE have no effect.
- Reset in RUN or DONE: aborts the operation immediately to the reset values; no partial result is ever flagged valid.
- Counter: width clog2(N), minimum 1 bit. It never exceeds N-1; wrap-around is not relied on.
- N = 1 (CHUNK = WIDTH): RUN lasts one cycle; out_valid rises 1 cycle after accept.

Test Plan:
- WIDTH=16, CHUNK=4, add 0x1234 + 0x0FFF -> sum=0x2233, carry=0, overflow=0, zero=0; out_valid rises exactly 4 cycles after the accepting edge.
- Add 0xFFFF + 0x0001 -> sum=0x0000, carry=1, zero=1, overflow=0. Add 0x7FFF + 0x0001 -> sum=0x8000, overflow=1, carry=0.
- Subtract 0x0005 - 0x0007 -> sum=0xFFFE, carry=0 (borrow), overflow=0. Subtract 0x8000 - 0x0001 -> sum=0x7FFF, carry=1, overflow=1.
- Back-pressure:
  - stimulus: hold out_ready=0 for 10 cycles after out_valid, and toggle a/b/in_valid meanwhile;
  - required: out_valid and sum stay stable, in_ready stays 0;
  - after out_ready=1 for one edge: in_ready=1 on the next cycle.
- Reset mid-operation: assert rst 2 cycles into RUN -> all outputs return to reset values at once, in_ready=1 after release, no out_valid pulse; a following 0x0001 + 0x0001 yields sum=0x0002.
- Parameter sweep:
  - CHUNK=16 (N=1) and CHUNK=1 (N=16);
  - 1000 random add/sub operations each, checked against a reference model for sum, carry, overflow and zero;
  - required latency: 1 and 16 cycles respectively.
